uart_tx_frame: RTL and testbench

- Transmit end of the control-to-UART path. Runs entirely in the UART sampling clock domain.
- Accepts one byte from the synchronized control interface and serializes it as an 8N1 frame on the serial line.
- Returns a stretched ack that the control domain can sample safely through its synchronizer.
- Sits between the control-side synchronizer and the board TX pin.

---
 rtl/uart_tx_frame.sv | 102 ++++++++++
 tb/tb_uart_tx_frame.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: serializes one accepted word as an N-bit, no-parity, one-stop-bit frame.
// After the frame it holds a stretched ack that the control domain can sample.
module uart_tx_frame #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int ACK_HOLD     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_serial,
    output logic                 tx_busy,
    output logic                 tx_ack
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam int AW = $clog2(ACK_HOLD + 1);
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, ACK} state_t;
    state_t               state_q, state_d;
    logic [CW-1:0]        cyc_q, cyc_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [AW-1:0]        ack_q, ack_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 serial_q, ready_q, busy_q, ack_out_q;
    logic                 cyc_end;
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        bit_d   = bit_q;
        ack_d   = ack_q;
        shift_d = shift_q;
        cyc_end = cyc_q == CW'(CLKS_PER_BIT - 1);
        case (state_q)
            IDLE: if (tx_valid) begin
                shift_d = tx_data;
                cyc_d   = '0;
                bit_d   = '0;
                state_d = START;
            end
            START: begin
                cyc_d = cyc_end ? '0 : cyc_q + 1'b1;
                if (cyc_end) begin
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                cyc_d = cyc_end ? '0 : cyc_q + 1'b1;
                if (cyc_end) begin
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == BW'(DATA_BITS - 1)) state_d = STOP;
                end
            end
            STOP: begin
                cyc_d = cyc_end ? '0 : cyc_q + 1'b1;
                if (cyc_end) begin
                    ack_d   = '0;
                    state_d = ACK;
                end
            end
            ACK: begin
                ack_d = ack_q + 1'b1;
                if (ack_q == AW'(ACK_HOLD - 1)) begin
                    ack_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    // Outputs are registered from the next state so the line changes on the accepting edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cyc_q     <= '0;
            bit_q     <= '0;
            ack_q     <= '0;
            shift_q   <= '0;
            serial_q  <= 1'b1;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            ack_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            bit_q     <= bit_d;
            ack_q     <= ack_d;
            shift_q   <= shift_d;
            serial_q  <= (state_d == START) ? 1'b0 : (state_d == DATA) ? shift_d[0] : 1'b1;
            ready_q   <= state_d == IDLE;
            busy_q    <= state_d inside {START, DATA, STOP};
            ack_out_q <= state_d == ACK;
        end
    end
    assign tx_serial = serial_q;
    assign tx_ready  = ready_q;
    assign tx_busy   = busy_q;
    assign tx_ack    = ack_out_q;
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: checks a default instance and a small-parameter instance against a frame-timing model.
module tb_uart_tx_frame;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] da = '0;
    logic       va = 1'b0;
    logic       sa, ra, ba, aa;
    logic [4:0] db = '0;
    logic       vb = 1'b0;
    logic       sb, rb, bb, ab;
    int         checks = 0;
    int         errors = 0;
    int         kk = 0;
    int         acks_a = 0;
    logic       aa_prev = 1'b0;
    int         n = 0;
    bit         act_a = 0, act_b = 0;
    int         t_a = 0, t_b = 0;
    logic [7:0] d_a = '0, d_b = '0;

    always #5 clk = ~clk;

    uart_tx_frame dut_a (
        .clk(clk), .rst_n(rst_n), .tx_data(da), .tx_valid(va),
        .tx_ready(ra), .tx_serial(sa), .tx_busy(ba), .tx_ack(aa)
    );
    uart_tx_frame #(.CLKS_PER_BIT(2), .DATA_BITS(5), .ACK_HOLD(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .tx_data(db), .tx_valid(vb),
        .tx_ready(rb), .tx_serial(sb), .tx_busy(bb), .tx_ack(ab)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // {serial, ready, busy, ack} for cycle k after the accepting edge of a frame carrying d.
    function automatic logic [3:0] model(input bit act, input int k, input int cpb,
                                         input int nb, input int ah, input logic [7:0] d);
        if (!act || k > (nb + 2) * cpb + ah) return 4'b1100;
        if (k <= cpb) return 4'b0010;
        if (k <= (nb + 1) * cpb) return {d[(k - 1) / cpb - 1], 3'b010};
        if (k <= (nb + 2) * cpb) return 4'b1010;
        return 4'b1001;
    endfunction

    always @(posedge clk) begin
        logic [3:0] ea, eb;
        ea = model(act_a, n - t_a, 16, 8, 16, d_a);
        eb = model(act_b, n - t_b, 2, 5, 1, d_b);
        if (!rst_n) begin
            act_a <= 0;
            act_b <= 0;
        end else begin
            if (ea[2] && va) begin act_a <= 1; t_a <= n; d_a <= da; end
            if (eb[2] && vb) begin act_b <= 1; t_b <= n; d_b <= {3'b0, db}; end
        end
        n <= n + 1;
    end

    always @(negedge clk) begin
        logic [3:0] ea, eb;
        ea = rst_n ? model(act_a, n - t_a, 16, 8, 16, d_a) : 4'b1100;
        eb = rst_n ? model(act_b, n - t_b, 2, 5, 1, d_b) : 4'b1100;
        chk("a_serial", 32'(sa), 32'(ea[3]));
        chk("a_ready",  32'(ra), 32'(ea[2]));
        chk("a_busy",   32'(ba), 32'(ea[1]));
        chk("a_ack",    32'(aa), 32'(ea[0]));
        chk("b_serial", 32'(sb), 32'(eb[3]));
        chk("b_ready",  32'(rb), 32'(eb[2]));
        chk("b_busy",   32'(bb), 32'(eb[1]));
        chk("b_ack",    32'(ab), 32'(eb[0]));
        if (aa === 1'b1 && aa_prev !== 1'b1) acks_a++;
        aa_prev = aa;
    end

    task automatic adv(input int t);
        while (kk < t) begin
            @(posedge clk);
            #1;
            kk++;
        end
    endtask

    task automatic accept_a(input logic [7:0] d);
        @(posedge clk);
        #1;
        da = d;
        va = 1'b1;
        @(posedge clk);
        #1;
        kk = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

    initial begin
        int base;
        #3 rst_n = 1'b0;
        #1;
        chk("rst_serial", 32'(sa), 32'd1);
        chk("rst_ready",  32'(ra), 32'd1);
        chk("rst_busy",   32'(ba), 32'd0);
        chk("rst_ack",    32'(aa), 32'd0);
        chk("rst_b_ready", 32'(rb), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        // Single 0xA5 frame, literal timing points.
        base = acks_a;
        accept_a(8'hA5);
        va = 1'b0;
        chk("a5_k1", 32'(sa), 32'd0);
        adv(16);  chk("a5_k16", 32'(sa), 32'd0);
        adv(17);  chk("a5_b0", 32'(sa), 32'd1);
        adv(33);  chk("a5_b1", 32'(sa), 32'd0);
        adv(49);  chk("a5_b2", 32'(sa), 32'd1);
        adv(96);  chk("a5_b4", 32'(sa), 32'd0);
        adv(97);  chk("a5_b5", 32'(sa), 32'd1);
        adv(144); chk("a5_b7", 32'(sa), 32'd1);
        adv(145); chk("a5_stop", 32'(sa), 32'd1); chk("a5_stop_busy", 32'(ba), 32'd1);
        adv(160); chk("a5_k160_busy", 32'(ba), 32'd1);
        adv(161); chk("a5_ack_on", 32'(aa), 32'd1); chk("a5_k161_busy", 32'(ba), 32'd0);
        chk("a5_k161_ready", 32'(ra), 32'd0);
        adv(176); chk("a5_ack_k176", 32'(aa), 32'd1);
        adv(177); chk("a5_ready_back", 32'(ra), 32'd1); chk("a5_ack_off", 32'(aa), 32'd0);
        chk("a5_ack_count", 32'(acks_a - base), 32'd1);
        // Back-to-back 0x00 then 0xFF with tx_valid held.
        base = acks_a;
        accept_a(8'h00);
        da = 8'hFF;
        adv(144); chk("b2b_first_b7", 32'(sa), 32'd0);
        adv(160); chk("b2b_stop", 32'(sa), 32'd1);
        adv(177); chk("b2b_gap", 32'(sa), 32'd1); chk("b2b_ready", 32'(ra), 32'd1);
        adv(178); chk("b2b_second_start", 32'(sa), 32'd0); chk("b2b_busy2", 32'(ba), 32'd1);
        va = 1'b0;
        adv(194); chk("b2b_ff_b0", 32'(sa), 32'd1);
        adv(354); chk("b2b_idle", 32'(ra), 32'd1);
        chk("b2b_ack_count", 32'(acks_a - base), 32'd2);
        // tx_data changes mid-frame must not alter the frame.
        accept_a(8'h3C);
        va = 1'b0;
        adv(17);  chk("stab_b0", 32'(sa), 32'd0);
        adv(49);  chk("stab_b2", 32'(sa), 32'd1);
        adv(50);  da = 8'hC3;
        adv(81);  chk("stab_b4", 32'(sa), 32'd1);
        adv(129); chk("stab_b7", 32'(sa), 32'd0);
        adv(177); chk("stab_ready", 32'(ra), 32'd1);
        // Reset during bit 4 of 0x55 aborts without ack.
        base = acks_a;
        accept_a(8'h55);
        va = 1'b0;
        adv(85);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_serial", 32'(sa), 32'd1);
        chk("mid_rst_busy",   32'(ba), 32'd0);
        chk("mid_rst_ready",  32'(ra), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        chk("mid_rst_no_ack", 32'(acks_a - base), 32'd0);
        accept_a(8'h55);
        va = 1'b0;
        adv(81);  chk("redo_b4", 32'(sa), 32'd1);
        adv(97);  chk("redo_b5", 32'(sa), 32'd0);
        adv(177); chk("redo_ready", 32'(ra), 32'd1);
        chk("redo_ack_count", 32'(acks_a - base), 32'd1);
        // Small-parameter instance: 2 clocks/bit, 5 data bits, 1-cycle ack.
        @(posedge clk);
        #1;
        db = 5'h13;
        vb = 1'b1;
        @(posedge clk);
        #1;
        vb = 1'b0;
        kk = 1;
        chk("p_start", 32'(sb), 32'd0);
        adv(3);  chk("p_b0", 32'(sb), 32'd1);
        adv(5);  chk("p_b1", 32'(sb), 32'd1);
        adv(7);  chk("p_b2", 32'(sb), 32'd0);
        adv(9);  chk("p_b3", 32'(sb), 32'd0);
        adv(11); chk("p_b4", 32'(sb), 32'd1);
        adv(14); chk("p_stop", 32'(sb), 32'd1); chk("p_stop_busy", 32'(bb), 32'd1);
        adv(15); chk("p_ack", 32'(ab), 32'd1); chk("p_ack_busy", 32'(bb), 32'd0);
        adv(16); chk("p_ack_off", 32'(ab), 32'd0); chk("p_ready", 32'(rb), 32'd1);
        repeat (4) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
